mem_resp_slave: RTL and testbench

- Handshaked data-memory responder: the target end of the core's load/store request interface.
- Replaces the zero-latency memory when testing multi-cycle cores, and serves as the reference target for bus verification.
- Accepts byte-strobed read/write requests over a valid/ready channel and returns in-order responses after a programmable fixed latency, with bounded outstanding requests and response back-pressure.

---
 rtl/mem_resp_slave.sv | 112 +++++++++++
 tb/tb_mem_resp_slave.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_resp_slave.sv
// Handshaked word memory target: byte-strobed requests in, in-order responses out
// after a fixed latency, with a bounded outstanding-request queue.
module mem_resp_slave #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned DEPTH           = 1024,
    parameter int unsigned LATENCY         = 2,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic                    req_write,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_write,
    output logic                    rsp_err
);
    localparam int unsigned PW = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SW = DATA_WIDTH / 8;
    localparam logic [3:0]    LAT     = 4'(LATENCY);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DATA_WIDTH-1:0] q_rdata [MAX_OUTSTANDING];
    logic                  q_write [MAX_OUTSTANDING];
    logic                  q_err   [MAX_OUTSTANDING];
    logic [3:0]            q_age   [MAX_OUTSTANDING];

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;

    logic [ADDR_WIDTH-3:0] word_idx;
    logic [MW-1:0]         mem_idx;
    logic                  addr_err;
    logic                  push;
    logic                  pop;
    logic                  head_ready;
    logic                  unused_addr_lsbs;

    assign word_idx         = req_addr[ADDR_WIDTH-1:2];
    assign mem_idx          = word_idx[MW-1:0];
    assign addr_err         = (64'(word_idx) >= 64'(DEPTH));
    assign unused_addr_lsbs = ^req_addr[1:0];

    assign req_ready = (count < MAX_CNT);
    assign push      = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;

    // Response side depends only on registered queue state, never on rsp_ready.
    assign head_ready = (count != '0) && (q_age[rd_ptr] == LAT);
    assign rsp_valid  = head_ready;
    assign rsp_rdata  = head_ready ? q_rdata[rd_ptr] : '0;
    assign rsp_write  = head_ready ? q_write[rd_ptr] : 1'b0;
    assign rsp_err    = head_ready ? q_err[rd_ptr]   : 1'b0;

    // Storage is deliberately left out of reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (push && req_write && !addr_err) begin
            for (int i = 0; i < SW; i++) begin
                if (req_wstrb[i]) begin
                    mem[mem_idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                q_rdata[i] <= '0;
                q_write[i] <= 1'b0;
                q_err[i]   <= 1'b0;
                q_age[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                if (q_age[i] != LAT) begin
                    q_age[i] <= q_age[i] + 4'd1;
                end
            end
            // Read data is captured here, before this edge's storage update lands.
            if (push) begin
                q_rdata[wr_ptr] <= (req_write || addr_err) ? '0 : mem[mem_idx];
                q_write[wr_ptr] <= req_write;
                q_err[wr_ptr]   <= addr_err;
                q_age[wr_ptr]   <= 4'd1;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_resp_slave.sv
// Bench for mem_resp_slave: a LATENCY=2 and a LATENCY=1 instance checked every cycle
// against a queue/array reference model.
module tb_mem_resp_slave;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_ready;

    logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_write, a_rsp_err;
    logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_write, b_rsp_err;
    logic [31:0] a_rsp_rdata, b_rsp_rdata;
    logic        req_ready, rsp_valid, rsp_write, rsp_err;
    logic [31:0] rsp_rdata;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    assign a_req_valid = req_valid & ~sel;
    assign b_req_valid = req_valid & sel;
    assign req_ready   = sel ? b_req_ready : a_req_ready;
    assign rsp_valid   = sel ? b_rsp_valid : a_rsp_valid;
    assign rsp_rdata   = sel ? b_rsp_rdata : a_rsp_rdata;
    assign rsp_write   = sel ? b_rsp_write : a_rsp_write;
    assign rsp_err     = sel ? b_rsp_err   : a_rsp_err;

    mem_resp_slave #(.LATENCY(2)) u_lat2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(a_rsp_rdata),
        .rsp_write(a_rsp_write), .rsp_err(a_rsp_err)
    );

    mem_resp_slave #(.LATENCY(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(b_rsp_rdata),
        .rsp_write(b_rsp_write), .rsp_err(b_rsp_err)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        write;
        logic        err;
        int          acc;
    } ent_t;

    ent_t        q[$];
    logic [31:0] mem_m [2][1024];
    int          cyc = 0;
    bit          last_acc;
    int          acc_cyc;
    int          first_pop;
    int          last_pop;
    int          pop_cnt;
    logic [31:0] last_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: compare outputs against the model, then advance model across the edge.
    task automatic cycle();
        int   lat;
        bit   exp_valid;
        bit   acc;
        bit   pop;
        int   idx;
        ent_t e;
        lat       = sel ? 1 : 2;
        exp_valid = (q.size() > 0) && (cyc >= q[0].acc + lat - 1);
        check("req_ready", 32'(req_ready), 32'(q.size() < 4));
        check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
        if (exp_valid) begin
            check("rsp_rdata", rsp_rdata, q[0].rdata);
            check("rsp_write", 32'(rsp_write), 32'(q[0].write));
            check("rsp_err", 32'(rsp_err), 32'(q[0].err));
        end
        acc = req_valid && req_ready;
        pop = rsp_valid && rsp_ready;
        if (pop) last_rdata = rsp_rdata;
        @(posedge clk);
        cyc++;
        last_acc = acc;
        if (pop) begin
            if (q.size() > 0) void'(q.pop_front());
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
            pop_cnt++;
        end
        if (acc) begin
            acc_cyc = cyc;
            idx     = int'(req_addr[31:2]);
            e.err   = (idx >= 1024);
            e.write = req_write;
            e.acc   = cyc;
            e.rdata = (req_write || e.err) ? 32'h0 : mem_m[sel][idx];
            q.push_back(e);
            if (req_write && !e.err) begin
                for (int b = 0; b < 4; b++)
                    if (req_wstrb[b]) mem_m[sel][idx][8*b +: 8] = req_wdata[8*b +: 8];
            end
        end
        @(negedge clk);
    endtask

    task automatic send(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_wstrb = s;
        do begin
            cycle();
            n++;
        end while (!last_acc && n < 20);
        if (!last_acc) check("send_timeout", 32'(n), 32'(0));
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        while (q.size() > 0 && n < 50) begin
            cycle();
            n++;
        end
        if (q.size() > 0) check("drain_timeout", 32'(q.size()), 32'(0));
        cycle();
    endtask

    initial begin
        rst_n     = 1'b0;
        sel       = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        rsp_ready = 1'b1;
        first_pop = -1;
        last_pop  = -1;
        pop_cnt   = 0;
        @(negedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'(1));
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_write", 32'(rsp_write), 32'(0));
        check("rst_rsp_err", 32'(rsp_err), 32'(0));
        rst_n = 1'b1;
        cycle();

        for (int i = 0; i < 16; i++) send(1'b1, 32'(i) << 2, $urandom, 4'hF);
        drain();

        // Write then read at 0x10.
        send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        send(1'b0, 32'h10, 32'h0, 4'h0);
        drain();
        check("rw_readback", last_rdata, 32'hDEADBEEF);

        // Byte strobes, plus a no-op write that still responds.
        send(1'b1, 32'h20, 32'h11223344, 4'hF);
        send(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
        send(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0);
        send(1'b0, 32'h22, 32'h0, 4'h0);
        drain();
        check("strobe_merge", last_rdata, 32'h11BB33DD);

        // Back-pressure: four reads fill the queue, fifth waits for the first pop.
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(1'b0, 32'(i + 1) << 2, 32'h0, 4'h0);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0;
        for (int i = 0; i < 3; i++) cycle();
        check("bp_held_off", 32'(q.size()), 32'(4));
        rsp_ready = 1'b1;
        first_pop = -1;
        begin
            int n = 0;
            do begin
                cycle();
                n++;
            end while (!last_acc && n < 10);
            if (!last_acc) check("bp_5th_timeout", 32'(n), 32'(0));
        end
        req_valid = 1'b0;
        check("bp_5th_after_pop", 32'(acc_cyc - first_pop), 32'(1));
        drain();

        // Out-of-range read and write; word 0 must be untouched.
        send(1'b0, 32'h1000, 32'h0, 4'h0);
        send(1'b1, 32'h1000, 32'hCAFEF00D, 4'hF);
        send(1'b0, 32'h0, 32'h0, 4'h0);
        drain();
        check("oor_word0", last_rdata, mem_m[0][0]);

        // LATENCY=1 throughput: write/read pairs back-to-back, one response per cycle.
        sel = 1'b1;
        cycle();
        first_pop = -1;
        pop_cnt   = 0;
        for (int i = 0; i < 8; i++) begin
            send(1'b1, 32'h14, $urandom, 4'hF);
            send(1'b0, 32'h14, 32'h0, 4'h0);
        end
        drain();
        check("tput_pops", 32'(pop_cnt), 32'(16));
        check("tput_span", 32'(last_pop - first_pop), 32'(15));
        sel = 1'b0;
        cycle();

        // Random traffic with random response back-pressure.
        for (int i = 0; i < 300; i++) begin
            int w;
            w         = ($urandom_range(7) == 0) ? 1024 + int'($urandom_range(100)) : int'($urandom_range(15));
            req_valid = ($urandom_range(3) != 0);
            req_write = $urandom_range(1) == 1;
            req_addr  = (32'(w) << 2) | 32'($urandom_range(3));
            req_wdata = $urandom;
            req_wstrb = 4'($urandom_range(15));
            rsp_ready = ($urandom_range(9) < 7);
            cycle();
        end
        drain();

        // Reset with three requests in flight; committed storage must survive.
        rsp_ready = 1'b0;
        send(1'b1, 32'h24, 32'h5A5AA5A5, 4'hF);
        send(1'b0, 32'h24, 32'h0, 4'h0);
        send(1'b0, 32'h10, 32'h0, 4'h0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("mid_rst_req_ready", 32'(req_ready), 32'(1));
        q.delete();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        send(1'b0, 32'h24, 32'h0, 4'h0);
        drain();
        check("post_rst_data", last_rdata, 32'h5A5AA5A5);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
